// File: rtl/instr_word_encoder.sv
// MIPS instruction-word encoder: mnemonic plus register/immediate fields in, 32-bit words out.
// Encoded words are queued in a small FIFO and tagged with an auto-incrementing byte address.
module instr_word_encoder #(
    parameter int                    DEPTH      = 4,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [4:0]               op_in,
    input  logic [4:0]               rs_in,
    input  logic [4:0]               rt_in,
    input  logic [4:0]               rd_in,
    input  logic [4:0]               shamt_in,
    input  logic [15:0]              imm_in,
    input  logic                     valid_in,
    output logic                     ready_out,
    input  logic                     flush_in,
    output logic [31:0]              instruction_out,
    output logic [ADDR_WIDTH-1:0]    address_out,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic [$clog2(DEPTH):0]   count_out,
    output logic                     error_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,  OP_ADDU  = 5'd1,  OP_SUB  = 5'd2,  OP_AND  = 5'd3,
        OP_OR    = 5'd4,  OP_NOR   = 5'd5,  OP_SLL  = 5'd6,  OP_SRL  = 5'd7,
        OP_SLT   = 5'd8,  OP_ADDI  = 5'd9,  OP_ADDIU = 5'd10, OP_ANDI = 5'd11,
        OP_ORI   = 5'd12, OP_SLTI  = 5'd13, OP_SLTIU = 5'd14, OP_LUI  = 5'd15,
        OP_BEQ   = 5'd16, OP_BNE   = 5'd17, OP_LW   = 5'd18, OP_SW   = 5'd19
    } mnemonicT;

    mnemonicT          mnemonic;
    logic              isRType;
    logic              zeroRs;
    logic              keepShamt;
    logic              opLegal;
    logic [5:0]        funct;
    logic [5:0]        opcode;
    logic [4:0]        rsField;
    logic [4:0]        shamtField;
    logic [31:0]       encWord;

    logic [31:0]       fifoMem [DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_WIDTH-1:0] addrReg;
    logic              errReg;

    logic              pushReq;
    logic              popReq;
    logic              doWrite;

    assign mnemonic = mnemonicT'(op_in);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        isRType   = 1'b0;
        zeroRs    = 1'b0;
        keepShamt = 1'b0;
        opLegal   = 1'b1;
        funct     = 6'h00;
        opcode    = 6'h00;
        case (mnemonic)
            OP_ADD:   begin isRType = 1'b1; funct = 6'h20; end
            OP_ADDU:  begin isRType = 1'b1; funct = 6'h21; end
            OP_SUB:   begin isRType = 1'b1; funct = 6'h22; end
            OP_AND:   begin isRType = 1'b1; funct = 6'h24; end
            OP_OR:    begin isRType = 1'b1; funct = 6'h25; end
            OP_NOR:   begin isRType = 1'b1; funct = 6'h27; end
            OP_SLL:   begin isRType = 1'b1; funct = 6'h00; zeroRs = 1'b1; keepShamt = 1'b1; end
            OP_SRL:   begin isRType = 1'b1; funct = 6'h02; zeroRs = 1'b1; keepShamt = 1'b1; end
            OP_SLT:   begin isRType = 1'b1; funct = 6'h2A; end
            OP_ADDI:  opcode = 6'h08;
            OP_ADDIU: opcode = 6'h09;
            OP_ANDI:  opcode = 6'h0C;
            OP_ORI:   opcode = 6'h0D;
            OP_SLTI:  opcode = 6'h0A;
            OP_SLTIU: opcode = 6'h0B;
            OP_LUI:   begin opcode = 6'h0F; zeroRs = 1'b1; end
            OP_BEQ:   opcode = 6'h04;
            OP_BNE:   opcode = 6'h05;
            OP_LW:    opcode = 6'h23;
            OP_SW:    opcode = 6'h2B;
            default:  opLegal = 1'b0;
        endcase
    end

    assign rsField    = zeroRs ? 5'd0 : rs_in;
    assign shamtField = keepShamt ? shamt_in : 5'd0;
    assign encWord    = isRType ? {6'h00, rsField, rt_in, rd_in, shamtField, funct}
                                : {opcode, rsField, rt_in, imm_in};

    assign ready_out = (count != CNT_W'(DEPTH));
    assign valid_out = (count != '0);
    assign pushReq   = valid_in && ready_out;
    assign popReq    = valid_out && ready_in;
    assign doWrite   = pushReq && opLegal && !flush_in;

    // NOTE: storage is deliberately not reset; valid_out masks stale entries, so clearing
    // the pointers and count is enough and the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (doWrite) begin
            fifoMem[wrPtr] <= encWord;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            addrReg <= BASE_ADDR;
            errReg  <= 1'b0;
        end else if (flush_in) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            count   <= '0;
            addrReg <= BASE_ADDR;
            errReg  <= 1'b0;
        end else begin
            if (doWrite) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (popReq) begin
                rdPtr   <= rdPtr + 1'b1;
                addrReg <= addrReg + ADDR_WIDTH'(4);
            end
            case ({doWrite, popReq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Illegal mnemonics are dropped, but the fault stays visible until flush or reset.
            if (pushReq && !opLegal) begin
                errReg <= 1'b1;
            end
        end
    end

    assign instruction_out = valid_out ? fifoMem[rdPtr] : 32'h0;
    assign address_out     = addrReg;
    assign count_out       = count;
    assign error_out       = errReg;

endmodule

// File: doc/instr_word_encoder.md
Name: instr_word_encoder

Overview:
- Sequential encoder for the mnemonic set the ALU control decoder consumes. Turns a mnemonic code plus register/immediate fields into a 32-bit MIPS instruction word.
- Sits between the test/boot sequencer and the instruction-memory write port.
- Buffers encoded words in a small FIFO and tags each outgoing word with an auto-incrementing byte address.
- Valid/ready handshake on both sides.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
ADDR_WIDTH, 32, width of address_out
BASE_ADDR, 0, first address issued after reset/flush (word aligned)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
op_in  in  5  mnemonic code (table below)
rs_in  in  5  rs field
rt_in  in  5  rt field
rd_in  in  5  rd field
shamt_in  in  5  shift amount
imm_in  in  16  immediate/offset
valid_in  in  1  input request valid
ready_out  out  1  encoder can accept
flush_in  in  1  synchronous clear of FIFO, address, error
instruction_out  out  32  encoded word at FIFO head
address_out  out  ADDR_WIDTH  byte address for head word
valid_out  out  1  head word valid
ready_in  in  1  downstream accepts
count_out  out  $clog2(DEPTH)+1  FIFO occupancy
error_out  out  1  sticky illegal-opcode flag

Behaviour:
- Mnemonic codes (decimal) and their encodings:
  - R-type, opcode 0, funct: 0 ADD 0x20; 1 ADDU 0x21; 2 SUB 0x22; 3 AND 0x24; 4 OR 0x25; 5 NOR 0x27; 6 SLL 0x00; 7 SRL 0x02; 8 SLT 0x2A.
  - I-type opcode: 9 ADDI 0x08; 10 ADDIU 0x09; 11 ANDI 0x0C; 12 ORI 0x0D; 13 SLTI 0x0A; 14 SLTIU 0x0B; 15 LUI 0x0F; 16 BEQ 0x04; 17 BNE 0x05; 18 LW 0x23; 19 SW 0x2B.
  - Codes 20-31 are illegal.
- R-type format: {6'h00, rs, rt, rd, shamt, funct}.
  - SLL/SRL force rs=0.
  - All other R-type ops force shamt=0.
- I-type format: {opcode, rs, rt, imm}.
  - LUI forces rs=0.
  - rd_in and shamt_in are ignored.
- Encoding is combinational on the inputs and written into the FIFO on the push.
- Push: valid_in && ready_out. ready_out = (count_out != DEPTH).
  - Illegal code on a push: no FIFO write, error_out set to 1 next cycle and held (sticky).
- Pop: valid_out && ready_in.
  - valid_out = (count_out != 0).
  - instruction_out is always the FIFO head, and holds stable while valid_out && !ready_in.
- Latency: a legal push in cycle N is visible at the output in cycle N+1 (no combinational pass-through).
- Simultaneous push and pop:
  - Allowed whenever not full and not empty; count unchanged.
  - When full, ready_out=0, so no push occurs even if a pop happens that cycle.
- Pointers wrap modulo DEPTH.
- Address counter:
  - address_out is BASE_ADDR plus 4 times the number of pops since reset/flush.
  - Increments by 4 on each pop; wraps modulo 2^ADDR_WIDTH.
- flush_in (synchronous, highest priority):
  - Empties the FIFO, sets the address to BASE_ADDR, clears error_out.
  - A push or pop in the same cycle is discarded.
- Reset (asynchronous, any time, including mid-burst):
  - count_out=0, valid_out=0, ready_out=1 once rst_n deasserted.
  - instruction_out=0, address_out=BASE_ADDR, error_out=0.
  - FIFO contents are don't-care but never presented, since valid_out=0.

Test Plan:
- ADD, rs=1 rt=2 rd=3, ready_in=1 -> next cycle valid_out=1, instruction_out=0x00221820, address_out=0x0; address becomes 0x4 after the pop.
- ADDI rs=0 rt=8 imm=0xFFFF -> 0x2008FFFF. LW rs=29 rt=9 imm=4 -> 0x8FA90004. SLL rs_in=7 rt=4 rd=2 shamt=3 -> 0x000410C0 (rs forced 0).
- ready_in=0, push 5 legal ops back-to-back -> 4 accepted, ready_out=0 at count_out=4, fifth held. Then ready_in=1 -> 5 words emitted in order at addresses 0x0, 0x4, 0x8, 0xC, 0x10.
- Push op_in=25 -> count_out unchanged, error_out=1 and held through later legal pushes. flush_in=1 -> error_out=0, count_out=0, address_out=0x0.
- Steady streaming with valid_in=ready_in=1 -> one word per cycle, count_out constant at 1, no gaps.
- rst_n low for 1 cycle with 3 entries queued -> valid_out=0, count_out=0, address_out=BASE_ADDR immediately (asynchronous). After release, the first new push emits at BASE_ADDR.
